// File: rtl/frogger_pkg.sv
// Shared definitions for the frogger front end: direction indices, arbiter
// priority, repeat FSM states and default timing.
package frogger_pkg;
   localparam int NUM_DIRS = 4;
   localparam int UP    = 0;
   localparam int DOWN  = 1;
   localparam int RIGHT = 2;
   localparam int LEFT  = 3;

   // Highest priority first.
   localparam int PRIO [NUM_DIRS] = '{UP, DOWN, RIGHT, LEFT};

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rep_state_t;

   // 100 MHz board timing, then the short values used in simulation.
   localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
   localparam int REPEAT_DELAY_DEF    = 50_000_000;
   localparam int REPEAT_PERIOD_DEF   = 25_000_000;
   localparam int DEBOUNCE_CYCLES_SIM = 4;
   localparam int REPEAT_DELAY_SIM    = 10;
   localparam int REPEAT_PERIOD_SIM   = 5;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/debounce_channel.sv
// One raw button: 2-FF synchroniser, stability counter and debounced level.
module debounce_channel #(
   parameter logic IDLE_LVL        = 1'b1,
   parameter int   DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic sync,
   output logic level
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync_meta;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta <= IDLE_LVL;
         sync      <= IDLE_LVL;
         level     <= IDLE_LVL;
         cnt       <= '0;
      end else begin
         sync_meta <= raw;
         sync      <= sync_meta;
         // Any agreeing sample restarts the stability window.
         if (sync == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
            level <= sync;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/button_conditioner.sv
// Debounced board buttons -> one-cycle active-low move pulses with auto-repeat,
// plus a debounced game reset level.
module button_conditioner
   import frogger_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_up_n,
   input  logic btn_down_n,
   input  logic btn_left_n,
   input  logic btn_right_n,
   input  logic btn_reset,
   output logic up,
   output logic down,
   output logic left,
   output logic right,
   output logic game_reset
);
   localparam int RCW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

   logic [NUM_DIRS-1:0] raw, sync, lvl, evt, pend, pend_nxt, grant, armed;
   logic                rst_lvl, unused_rst_sync, found;
   logic [1:0]          fill;
   rep_state_t          state [NUM_DIRS];
   logic [RCW-1:0]      rcnt  [NUM_DIRS];

   assign raw[UP]    = btn_up_n;
   assign raw[DOWN]  = btn_down_n;
   assign raw[RIGHT] = btn_right_n;
   assign raw[LEFT]  = btn_left_n;

   for (genvar g = 0; g < NUM_DIRS; g++) begin : g_dir
      debounce_channel #(.IDLE_LVL(1'b1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk, .reset, .raw(raw[g]), .sync(sync[g]), .level(lvl[g]));
   end

   debounce_channel #(.IDLE_LVL(1'b0), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
      .clk, .reset, .raw(btn_reset), .sync(unused_rst_sync), .level(rst_lvl));

   always_comb begin
      evt   = '0;
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_DIRS; i++) begin
         case (state[i])
            IDLE:    evt[i] = armed[i] & ~lvl[i];
            HOLD:    evt[i] = ~lvl[i] & (rcnt[i] == RCW'(REPEAT_DELAY));
            REPEAT:  evt[i] = ~lvl[i] & (rcnt[i] == RCW'(REPEAT_PERIOD));
            default: evt[i] = 1'b0;
         endcase
      end
      // New events merge into pend and can win in the same cycle they arrive.
      pend_nxt = rst_lvl ? '0 : (pend | evt);
      for (int p = 0; p < NUM_DIRS; p++) begin
         if (pend_nxt[PRIO[p]] && !found) begin
            grant[PRIO[p]] = 1'b1;
            found          = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fill       <= '0;
         pend       <= '0;
         armed      <= '0;
         up         <= 1'b1;
         down       <= 1'b1;
         right      <= 1'b1;
         left       <= 1'b1;
         game_reset <= 1'b0;
         for (int i = 0; i < NUM_DIRS; i++) begin
            state[i] <= IDLE;
            rcnt[i]  <= '0;
         end
      end else begin
         fill       <= {fill[0], 1'b1};
         game_reset <= rst_lvl;
         pend       <= pend_nxt & ~grant;
         up         <= ~grant[UP];
         down       <= ~grant[DOWN];
         right      <= ~grant[RIGHT];
         left       <= ~grant[LEFT];
         for (int i = 0; i < NUM_DIRS; i++) begin
            if (rst_lvl) begin
               state[i] <= IDLE;
               rcnt[i]  <= '0;
               armed[i] <= 1'b0;
            end else begin
               // A press only counts once the real input has been seen released,
               // so a button held through reset stays silent.
               if (fill[1] && sync[i] && lvl[i])
                  armed[i] <= 1'b1;
               case (state[i])
                  IDLE: if (evt[i]) begin
                     armed[i] <= 1'b0;
                     state[i] <= HOLD;
                     rcnt[i]  <= '0;
                  end
                  HOLD: if (lvl[i]) begin
                     state[i] <= IDLE;
                     rcnt[i]  <= '0;
                  end else if (evt[i]) begin
                     state[i] <= REPEAT;
                     rcnt[i]  <= '0;
                  end else begin
                     rcnt[i] <= rcnt[i] + 1'b1;
                  end
                  REPEAT: if (lvl[i]) begin
                     state[i] <= IDLE;
                     rcnt[i]  <= '0;
                  end else if (evt[i]) begin
                     rcnt[i] <= '0;
                  end else begin
                     rcnt[i] <= rcnt[i] + 1'b1;
                  end
                  default: state[i] <= IDLE;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_button_conditioner.sv
// Directed scenarios plus random button traffic, checked every cycle against
// a history-based model of debounce, repeat timing and priority arbitration.
module tb_button_conditioner;
   import frogger_pkg::*;

   localparam int DB   = DEBOUNCE_CYCLES_SIM;
   localparam int RD   = REPEAT_DELAY_SIM;
   localparam int RP   = REPEAT_PERIOD_SIM;
   localparam int MAXE = 4096;

   logic clk = 1'b0, reset = 1'b1;
   logic btn_up_n = 1'b1, btn_down_n = 1'b1, btn_left_n = 1'b1, btn_right_n = 1'b1;
   logic btn_reset = 1'b0;
   logic up, down, left, right, game_reset;

   always #5 clk = ~clk;

   button_conditioner #(.DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
      .clk(clk), .reset(reset), .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
      .btn_left_n(btn_left_n), .btn_right_n(btn_right_n), .btn_reset(btn_reset),
      .up(up), .down(down), .left(left), .right(right), .game_reset(game_reset));

   // channel index: UP, DOWN, RIGHT, LEFT, 4 = game reset
   int   n_checks = 0, n_err = 0;
   int   e = 0, e_rst = -100;
   bit   raw_h [5][MAXE];
   bit   m_lvl [5];
   int   m_flip [5];
   bit   m_held [4], m_armed [4], m_pend [4];
   int   m_press [4];
   logic [4:0] exp_out, obs;
   int   rel, both_low = 0;
   int   pulses [5], first [5];

   function automatic bit idle_of(input int ch);
      return ch < 4;
   endfunction

   // synchronised value the design sees just before edge k
   function automatic bit sync_at(input int ch, input int k);
      return (k - 2 > e_rst) ? raw_h[ch][k-2] : idle_of(ch);
   endfunction

   task automatic model_step(input bit rst);
      bit lv [5];
      bit evt [4];
      bit pn [4];
      bit won;
      int d, run, k, ch;
      int order [4] = '{UP, DOWN, RIGHT, LEFT};
      raw_h[UP][e]    = btn_up_n;
      raw_h[DOWN][e]  = btn_down_n;
      raw_h[RIGHT][e] = btn_right_n;
      raw_h[LEFT][e]  = btn_left_n;
      raw_h[4][e]     = btn_reset;
      if (rst) begin
         e_rst = e;
         for (int c = 0; c < 5; c++) begin m_lvl[c] = idle_of(c); m_flip[c] = e; end
         for (int i = 0; i < 4; i++) begin m_held[i] = 0; m_armed[i] = 0; m_pend[i] = 0; end
         exp_out = 5'b01111;
         e++;
         return;
      end
      lv = m_lvl;
      exp_out[4] = lv[4];
      for (int i = 0; i < 4; i++) begin
         evt[i] = 0;
         if (lv[4]) begin
            m_held[i] = 0; m_armed[i] = 0; m_pend[i] = 0;
         end else begin
            if (!m_held[i]) begin
               if (m_armed[i] && !lv[i]) begin
                  evt[i] = 1; m_held[i] = 1; m_press[i] = e; m_armed[i] = 0;
               end
            end else if (lv[i]) begin
               m_held[i] = 0;
            end else begin
               d = e - m_press[i];
               if (d == RD + 1 || (d > RD + 1 && (d - RD - 1) % (RP + 1) == 0)) evt[i] = 1;
            end
            if (e >= e_rst + 3 && sync_at(i, e) && lv[i]) m_armed[i] = 1;
         end
      end
      won = 0;
      for (int p = 0; p < 4; p++) begin
         ch = order[p];
         pn[ch] = !lv[4] && (m_pend[ch] || evt[ch]);
         exp_out[ch] = 1'b1;
         if (pn[ch] && !won) begin
            won = 1; exp_out[ch] = 1'b0; pn[ch] = 0;
         end
         m_pend[ch] = pn[ch];
      end
      // a level flips once D+1 consecutive synchronised samples disagree with it
      for (int c = 0; c < 5; c++) begin
         run = 0;
         k = e;
         while (k > m_flip[c] && k > e_rst && run <= DB + 1 && sync_at(c, k) != m_lvl[c]) begin
            run++; k--;
         end
         if (run == DB + 1) begin m_lvl[c] = ~m_lvl[c]; m_flip[c] = e; end
      end
      e++;
   endtask

   task automatic tick();
      @(posedge clk);
      if (e >= MAXE) begin
         $display("FAIL edge_budget observed=%0d limit=%0d", e, MAXE);
         $fatal(1, "edge budget exceeded");
      end
      model_step(reset);
      #1;
      obs = {game_reset, left, right, down, up};
      n_checks++;
      assert (obs === exp_out) else begin
         n_err++;
         $error("FAIL outputs edge=%0d observed=%b expected=%b", e - 1, obs, exp_out);
      end
      rel++;
      if ($countones(~obs[3:0]) > 1) both_low++;
      for (int c = 0; c < 5; c++)
         if (obs[c] != idle_of(c)) begin
            pulses[c]++;
            if (first[c] < 0) first[c] = rel;
         end
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic begin_scn();
      rel = -1;
      for (int c = 0; c < 5; c++) begin pulses[c] = 0; first[c] = -1; end
   endtask

   task automatic check(input string tag, input int observed, input int expected);
      n_checks++;
      assert (observed === expected) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   initial begin
      int len;
      begin_scn();
      idle(3);
      check("reset_state", int'(obs), 5'b01111);
      reset = 1'b0;
      idle(10);

      // clean press
      begin_scn();
      btn_up_n = 1'b0; idle(8); btn_up_n = 1'b1; idle(30);
      check("press_up_first", first[UP], 7);
      check("press_up_count", pulses[UP], 1);
      check("press_others", pulses[DOWN] + pulses[RIGHT] + pulses[LEFT], 0);

      // bounce shorter than the debounce window
      begin_scn();
      for (int i = 0; i < 20; i++) begin
         btn_left_n = ((i / 2) % 2) != 0;
         tick();
      end
      btn_left_n = 1'b1; idle(30);
      check("bounce_left", pulses[LEFT], 0);

      // auto-repeat: 7, 18, 24, 30, 36, 42
      begin_scn();
      btn_right_n = 1'b0; idle(40); btn_right_n = 1'b1; idle(30);
      check("repeat_first", first[RIGHT], 7);
      check("repeat_count", pulses[RIGHT], 6);

      // simultaneous press
      begin_scn();
      btn_down_n = 1'b0; btn_left_n = 1'b0; idle(12);
      btn_down_n = 1'b1; btn_left_n = 1'b1; idle(30);
      check("simul_down", first[DOWN], 7);
      check("simul_left", first[LEFT], 8);

      // reset during auto-repeat
      begin_scn();
      btn_up_n = 1'b0; idle(20);
      reset = 1'b1; tick(); reset = 1'b0;
      check("reset_mid_hold", int'(obs), 5'b01111);
      begin_scn();
      idle(25);
      check("held_through_reset", pulses[UP], 0);
      btn_up_n = 1'b1; idle(12);
      begin_scn();
      btn_up_n = 1'b0; idle(8); btn_up_n = 1'b1; idle(20);
      check("repress_first", first[UP], 7);

      // game reset while down held
      begin_scn();
      btn_down_n = 1'b0; btn_reset = 1'b1; idle(10);
      btn_reset = 1'b0; idle(20);
      btn_down_n = 1'b1; idle(30);
      check("game_reset_first", first[4], 7);
      check("game_reset_len", pulses[4], 10);
      check("game_reset_down", pulses[DOWN], 0);

      // random traffic
      for (int s = 0; s < 60; s++) begin
         btn_up_n    = $urandom_range(0, 99) < 60;
         btn_down_n  = $urandom_range(0, 99) < 60;
         btn_right_n = $urandom_range(0, 99) < 60;
         btn_left_n  = $urandom_range(0, 99) < 60;
         btn_reset   = $urandom_range(0, 99) < 8;
         reset       = $urandom_range(0, 99) < 4;
         len = $urandom_range(1, 30);
         for (int t = 0; t < len; t++) begin
            tick();
            reset = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
               case ($urandom_range(0, 3))
                  0: btn_up_n    = ~btn_up_n;
                  1: btn_down_n  = ~btn_down_n;
                  2: btn_right_n = ~btn_right_n;
                  default: btn_left_n = ~btn_left_n;
               endcase
            end
         end
      end
      check("one_dir_low", both_low, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
